// File: rtl/bsg_cache_sbuf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_cache_sbuf_fifo                                                        |
// | Store-buffer FIFO with byte-merged address snoop (youngest store wins).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bsg_cache_sbuf_fifo #(
  parameter int data_width_p = 128,
  parameter int addr_width_p = 32,
  parameter int els_p        = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic                          v_i,
  input  logic [data_width_p-1:0]       data_i,
  input  logic [addr_width_p-1:0]       addr_i,
  input  logic [data_width_p/8-1:0]     mask_i,
  output logic                          ready_o,

  output logic                          v_o,
  output logic [data_width_p-1:0]       data_o,
  output logic [addr_width_p-1:0]       addr_o,
  output logic [data_width_p/8-1:0]     mask_o,
  input  logic                          yumi_i,

  input  logic                          bypass_v_i,
  input  logic [addr_width_p-1:0]       bypass_addr_i,
  output logic [data_width_p-1:0]       bypass_data_o,
  output logic [data_width_p/8-1:0]     bypass_mask_o,

  output logic [$clog2(els_p+1)-1:0]    count_o
);

  localparam int MW     = data_width_p / 8;
  localparam int LG_MW  = $clog2(MW);
  localparam int PTR_W  = $clog2(els_p);
  localparam int PTR_W1 = PTR_W + 1;
  localparam int CNT_W  = $clog2(els_p + 1);

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(els_p - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(els_p);
  localparam logic [PTR_W1-1:0] ELS_WIDE = PTR_W1'(els_p);

  logic [data_width_p-1:0] data_q [els_p];
  logic [addr_width_p-1:0] addr_q [els_p];
  logic [MW-1:0]           mask_q [els_p];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_enq;
  logic w_deq;
  logic w_byp_en;
  logic w_in_hit;
  logic [els_p-1:0] w_slot_hit;

  logic [data_width_p-1:0] w_byp_data;
  logic [MW-1:0]           w_byp_mask;
  logic [PTR_W1-1:0]       w_idx_wide;
  logic [PTR_W-1:0]        w_idx;

  assign ready_o  = (count_q != FULL_CNT);
  assign v_o      = (count_q != '0);
  assign count_o  = count_q;
  assign data_o   = data_q[rptr_q];
  assign addr_o   = addr_q[rptr_q];
  assign mask_o   = mask_q[rptr_q];

  // Reset also blanks the snoop so nothing leaks out while reset is held.
  assign w_enq    = v_i & ready_o & ~reset_i;
  assign w_deq    = yumi_i & v_o;
  assign w_byp_en = bypass_v_i & ~reset_i;

  logic w_unused_byp_addr;
  assign w_unused_byp_addr = ^bypass_addr_i;

  assign w_in_hit = (addr_i[addr_width_p-1:LG_MW] == bypass_addr_i[addr_width_p-1:LG_MW]);

  for (genvar s = 0; s < els_p; s++) begin : g_slot
    assign w_slot_hit[s] = (addr_q[s][addr_width_p-1:LG_MW] == bypass_addr_i[addr_width_p-1:LG_MW]);
  end

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (w_enq) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (w_deq) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end
    case ({w_enq, w_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so later matches overwrite earlier bytes.
  always_comb begin
    w_byp_data = '0;
    w_byp_mask = '0;
    w_idx_wide = '0;
    w_idx      = '0;
    if (w_byp_en) begin
      for (int i = 0; i < els_p; i++) begin
        w_idx_wide = {1'b0, rptr_q} + PTR_W1'(i);
        if (w_idx_wide >= ELS_WIDE) begin
          w_idx_wide = w_idx_wide - ELS_WIDE;
        end
        w_idx = w_idx_wide[PTR_W-1:0];
        if ((CNT_W'(i) < count_q) && w_slot_hit[w_idx]) begin
          for (int b = 0; b < MW; b++) begin
            if (mask_q[w_idx][b]) begin
              w_byp_data[b*8 +: 8] = data_q[w_idx][b*8 +: 8];
              w_byp_mask[b]        = 1'b1;
            end
          end
        end
      end
      if (w_enq && w_in_hit) begin
        for (int b = 0; b < MW; b++) begin
          if (mask_i[b]) begin
            w_byp_data[b*8 +: 8] = data_i[b*8 +: 8];
            w_byp_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign bypass_data_o = w_byp_data;
  assign bypass_mask_o = w_byp_mask;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count/pointers only.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      data_q[wptr_q] <= data_i;
      addr_q[wptr_q] <= addr_i;
      mask_q[wptr_q] <= mask_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_cache_sbuf_fifo: yumi_i asserted while queue empty");
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/bsg_cache_sbuf_fifo.md
BSG_CACHE_SBUF_FIFO -- requirements
Module: bsg_cache_sbuf_fifo

Interface
REQ-001 SHALL have parameter data_width_p, default 128: entry data width in bits, a multiple of 8.
REQ-002 SHALL have parameter addr_width_p, default 32: byte address width.
REQ-003 SHALL have parameter els_p, default 4: queue depth, at least 2, need not be a power of two.
REQ-004 SHALL derive mask width as data_width_p/8 bits, called mw below.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port v_i, input, 1 bit: enqueue request.
REQ-008 SHALL have ports data_i (data_width_p), addr_i (addr_width_p) and mask_i (mw), all inputs: the store entry to enqueue.
REQ-009 SHALL have port ready_o, output, 1 bit: queue can accept an entry.
REQ-010 SHALL have port v_o, output, 1 bit: head entry valid.
REQ-011 SHALL have ports data_o (data_width_p), addr_o (addr_width_p) and mask_o (mw), all outputs: the head entry.
REQ-012 SHALL have port yumi_i, input, 1 bit: head entry consumed this cycle.
REQ-013 SHALL have ports bypass_v_i (1 bit) and bypass_addr_i (addr_width_p), inputs: snoop request.
REQ-014 SHALL have ports bypass_data_o (data_width_p) and bypass_mask_o (mw), outputs: merged snoop result.
REQ-015 SHALL have port count_o, output, clog2(els_p+1) bits: number of valid entries.

Function
REQ-016 SHALL enqueue at the rising edge when v_i and ready_o are both 1; ready_o SHALL equal (count_o != els_p).
REQ-017 SHALL dequeue the head entry at the rising edge when yumi_i is 1; yumi_i with v_o=0 is illegal and SHALL be flagged by a simulation assertion.
REQ-018 SHALL drive v_o as (count_o != 0); data_o, addr_o and mask_o reflect the head entry and are don't-care while v_o=0.
REQ-019 SHALL have one cycle of enqueue-to-v_o latency, with no combinational path from data_i to data_o.
REQ-020 SHALL preserve FIFO order, with read and write pointers wrapping from els_p-1 to 0.
REQ-021 On simultaneous enqueue and dequeue, SHALL hold count_o unchanged and advance both pointers; this is legal at any non-full count.
REQ-022 When full, SHALL hold ready_o at 0 even if yumi_i=1 in the same cycle; there is no same-cycle slot reuse.
REQ-023 SHALL compute bypass combinationally; a candidate matches when its addr bits [addr_width_p-1 : log2(mw)] equal those of bypass_addr_i.
REQ-024 Bypass candidates SHALL be all valid entries plus the incoming entry when v_i and ready_o are both 1; the incoming entry counts as youngest.
REQ-025 The head entry being dequeued in the same cycle SHALL remain a bypass candidate.
REQ-026 For each byte b, bypass_data_o byte b SHALL come from the youngest matching candidate with mask bit b set; bypass_mask_o[b] SHALL be the OR of those mask bits.
REQ-027 Bytes with bypass_mask_o[b]=0, and all bytes when bypass_v_i=0, SHALL drive 0 on both bypass outputs.
REQ-028 Entries with mask_i all zero SHALL be enqueued normally and contribute nothing to bypass.

Reset
REQ-029 Asserting reset_i SHALL immediately clear pointers and count, regardless of clk_i.
REQ-030 During and after reset, outputs SHALL be: count_o=0, v_o=0, ready_o=1, bypass_mask_o=0, bypass_data_o=0.
REQ-031 Reset mid-operation SHALL discard all entries; the storage array is not reset.
REQ-032 The first enqueue after reset deassertion SHALL be accepted on the first rising edge with reset_i=0.

Verification
REQ-033 Fill/drain, els_p=4: enqueue data 1,2,3,4 -> ready_o=0 and count_o=4 after the 4th edge; yumi_i x4 -> data_o sequence 1,2,3,4, then v_o=0.
REQ-034 Wrap: run 10 interleaved enq/deq cycles at count_o=2 -> count_o stays 2, FIFO order intact across pointer wrap.
REQ-035 Full plus yumi: at count_o=4, drive v_i=1 and yumi_i=1 -> new entry not accepted, count_o=3 next cycle.
REQ-036 Bypass merge: entries addr 0x40 mask 0x000F data 0x..AABBCCDD, then addr 0x40 mask 0x0003 data 0x..1122; snoop 0x44 -> bypass_mask_o=0x000F, low 4 bytes 0xAABB1122.
REQ-037 Incoming bypass: empty queue, v_i=1, addr 0x80, mask 0xFFFF, snoop 0x80 same cycle -> bypass_mask_o=0xFFFF, bypass_data_o=data_i; with bypass_v_i=0 -> both bypass outputs 0.
REQ-038 Async reset: assert reset_i between clock edges at count_o=3 -> count_o=0, v_o=0, ready_o=1 immediately.
